// File: rtl/rr_mux_sequencer.sv
// -----------------------------------------------------------------------------
// rr_mux_sequencer
//
// Round-robin sequencer for an external 4:1 data mux. Four requesting channels
// share one output register. Each cycle the arbiter picks the next requesting
// channel after the most recently granted one, steers the external mux to it
// through sel, acknowledges it and captures the muxed word into the output
// register. The output register is a one-entry buffer with a valid/ready
// handshake. It can drain and reload on the same edge, so a steady stream moves
// one word per cycle.
//
// Parameters
//   width      data path width in bits
//
// Ports
//   clk        single clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   req[3:0]   per-channel request, held until acknowledged
//   ack[3:0]   per-channel accept (combinational, at most one bit high)
//   sel[1:0]   select for the external 4:1 mux (combinational)
//   din        external mux output, valid for sel in the same cycle
//   out_valid  output register holds a word
//   out_ready  downstream accepts the held word
//   out_data   captured word (registered)
//   out_chan   channel that out_data came from (registered)
// -----------------------------------------------------------------------------
module rr_mux_sequencer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  input  logic [width-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       out_chan
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Registered state
  state_t           state_q;
  state_t           state_d;
  logic [1:0]       last_q;
  logic [1:0]       last_d;
  logic [width-1:0] data_q;
  logic [width-1:0] data_d;
  logic [1:0]       chan_q;
  logic [1:0]       chan_d;

  // Arbitration signals
  logic             any_req_s;
  logic [1:0]       start_s;
  logic [7:0]       req_dbl_s;
  logic [3:0]       req_rot_s;
  logic [1:0]       offset_s;
  logic [1:0]       grant_s;
  logic             load_s;
  logic [3:0]       ack_s;

  assign any_req_s = |req;

  // The search starts one past the last granted channel. Doubling the request
  // vector lets a plain part-select perform the wrapping rotation.
  assign start_s   = last_q + 2'd1;
  assign req_dbl_s = {req, req};
  assign req_rot_s = req_dbl_s[{1'b0, start_s} +: 4];

  // Priority encoder over the rotated request vector (lowest bit wins)
  always_comb begin
    offset_s = 2'd0;
    casez (req_rot_s)
      4'b???1: offset_s = 2'd0;
      4'b??10: offset_s = 2'd1;
      4'b?100: offset_s = 2'd2;
      4'b1000: offset_s = 2'd3;
      default: offset_s = 2'd0;
    endcase
  end

  // Undo the rotation; the 2-bit add wraps 3 -> 0 naturally
  assign grant_s = start_s + offset_s;

  // A load happens when someone is requesting and the output register is free
  // or being drained on this same edge. Gating with rst_n keeps ack silent
  // while reset is asserted.
  assign load_s = any_req_s && ((state_q == EMPTY) || out_ready) && rst_n;

  // One-hot accept at the grant index, only on a load
  always_comb begin
    ack_s = 4'b0000;
    if (load_s) begin
      ack_s = 4'b0001 << grant_s;
    end else begin
      ack_s = 4'b0000;
    end
  end

  // Mux select: follow the grant while requests exist, otherwise park on last
  always_comb begin
    sel = last_q;
    if (any_req_s) begin
      sel = grant_s;
    end else begin
      sel = last_q;
    end
  end

  // Next-state logic for the EMPTY/FULL buffer
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (load_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Drain-and-reload keeps FULL; drain without a new request empties
        if (load_s) begin
          state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Capture path: word, source channel and round-robin pointer update on load
  always_comb begin
    last_d = last_q;
    data_d = data_q;
    chan_d = chan_q;
    if (load_s) begin
      last_d = grant_s;
      data_d = din;
      chan_d = grant_s;
    end else begin
      last_d = last_q;
      data_d = data_q;
      chan_d = chan_q;
    end
  end

  // State and datapath registers; last resets to 3 so channel 0 goes first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_q  <= 2'd3;
      data_q  <= {width{1'b0}};
      chan_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
    end
  end

  assign ack       = ack_s;
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: doc/rr_mux_sequencer.md
RR_MUX_SEQUENCER -- requirements
Module: rr_mux_sequencer

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the data path width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits: per-channel request (valid); req[i] held until transfer.
REQ-005 The block SHALL have port ack, output, 4 bits: per-channel accept, combinational; transfer of channel i occurs at an edge where req[i] && ack[i].
REQ-006 The block SHALL have port sel, output, 2 bits: combinational select driving the external 4:1 data mux.
REQ-007 The block SHALL have port din, input, width bits: external 4:1 mux output; it is a valid function of sel in the same cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: output register holds a word.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word at an edge where out_valid && out_ready.
REQ-010 The block SHALL have port out_data, output, width bits: registered captured word.
REQ-011 The block SHALL have port out_chan, output, 2 bits: registered index of the channel that out_data came from.

Function
REQ-012 The block SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1); out_valid SHALL be decoded directly from the state.
REQ-013 The block SHALL hold a 2-bit register last, the most recently granted channel.
REQ-014 The grant index SHALL be the first i with req[i]=1, searched in the order last+1, last+2, last+3, last (mod 4, wrap 3->0).
REQ-015 The block SHALL drive sel = grant index when |req=1, and sel = last when req=0.
REQ-016 The block SHALL define load = |req && (state==EMPTY || out_ready).
REQ-017 ack SHALL be one-hot at the grant index when load=1, and 4'b0000 otherwise; at most one ack bit SHALL ever be high.
REQ-018 On an edge with load=1, the block SHALL capture out_data<=din, out_chan<=grant index and last<=grant index, and SHALL go to FULL.
REQ-019 On an edge with state FULL, out_ready=1 and req=0, the block SHALL go to EMPTY; out_data and out_chan SHALL hold their values.
REQ-020 In FULL with out_ready=0, out_data, out_chan and last SHALL hold, and ack SHALL be 0 regardless of req.
REQ-021 In FULL with out_ready=1 and |req=1, the block SHALL drain and reload in the same edge, giving full throughput of one word per cycle with no bubble.
REQ-022 Fairness: a continuously asserted req[i] SHALL be granted within 4 loads.
REQ-023 A req[i] deasserted before it is acknowledged SHALL be dropped without side effects; correct handshaking never requires this.
REQ-024 Latency SHALL be 1 cycle, request-accept edge to out_valid=1.

Reset
REQ-025 When rst_n=0, the block SHALL immediately go to EMPTY with out_valid=0, out_data=0, out_chan=0 and last=3, so that channel 0 has first priority.
REQ-026 While rst_n=0, ack SHALL be 4'b0000.
REQ-027 A held word SHALL be discarded on a reset taken mid-operation.
REQ-028 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification (width=8; bench models the external mux: din = d[sel])
REQ-029 After reset, with req=4'b1111, d0..d3=0x05,0x0F,0x00,0xC0 and out_ready=1 held, the bench SHALL see ack sequence 0001, 0010, 0100, 1000, 0001 and out_data 0x05, 0x0F, 0x00, 0xC0 with out_chan 0,1,2,3, one word per cycle.
REQ-030 The bench SHALL apply req=4'b0100 with out_ready=0, then hold 5 cycles and release out_ready; it SHALL see one ack[2] pulse, out_valid stays 1, out_data stays constant, ack=0 throughout the stall, then EMPTY one cycle after release.
REQ-031 Wrap-around: the bench SHALL set last=3 by a channel-3 transfer, then apply req=4'b1001; the next grant SHALL be channel 0, then channel 3.
REQ-032 The bench SHALL pulse rst_n low asynchronously (between edges) while FULL with out_data=0xC0; out_valid=0, out_data=0x00 and ack=0 SHALL be immediate, and after release with req=4'b1111 the first grant SHALL be channel 0.
REQ-033 Starvation: with req[1] held and req[0], req[2], req[3] toggling randomly and out_ready random for 1000 cycles, the bench SHALL check that the gap between ack[1] pulses is never more than 4 loads, ack is always one-hot or zero, and out_chan always matches the data source.
